// File: rtl/nr_recip_pkg.sv
// nr_recip_pkg
//   Shared declarations for the Newton-Raphson reciprocal unit.
//   - state_t : FSM encoding (3 bits)
//   - ONE_FX / TWO_FX / THREE_FX : integer parts of the fixed-point
//     constants used by the iteration. Use to_fx() to place them on a
//     given fraction width.
//   - calc_qw() : quotient width (S1.FRAC_W -> FRAC_W+2 bits)
package nr_recip_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NORM   = 3'd1,
    ITER_A = 3'd2,
    ITER_B = 3'd3,
    SCALE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int unsigned ONE_FX   = 1;
  localparam int unsigned TWO_FX   = 2;
  localparam int unsigned THREE_FX = 3;

  // Quotient and internal datapath width: sign/integer bit, one more
  // integer bit, then FRAC_W fraction bits.
  function automatic int calc_qw(input int frac_w);
    return frac_w + 2;
  endfunction

  // Integer constant expressed in U2.frac_w fixed point (64-bit carrier).
  function automatic logic [63:0] to_fx(input int unsigned ival, input int frac_w);
    return 64'(ival) << frac_w;
  endfunction

endpackage

// File: rtl/nr_reciprocal_lead_one_norm.sv
// lead_one_norm
//   Combinational priority encoder and normaliser for the reciprocal unit.
//   Ports:
//     a       in  IN_W        unsigned magnitude of the divisor
//     p       out clog2(IN_W) index of the leading one (0 when a == 0)
//     m       out FRAC_W+2    a / 2^(p+1) in U2.FRAC_W, truncated; [0.5,1)
//     is_pow2 out 1           a is a non-zero power of two
module lead_one_norm #(
  parameter int IN_W   = 8,
  parameter int FRAC_W = 30
) (
  input  logic [IN_W-1:0]         a,
  output logic [$clog2(IN_W)-1:0] p,
  output logic [FRAC_W+1:0]       m,
  output logic                    is_pow2
);
  import nr_recip_pkg::*;

  localparam int PW = $clog2(IN_W);
  localparam int QW = calc_qw(FRAC_W);

  logic [PW:0] shamt;

  // Priority encoder: the highest set bit wins because later loop
  // iterations overwrite earlier ones.
  always_comb begin
    p = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (a[i]) begin
        p = PW'(i);
      end
    end
  end

  assign shamt = {1'b0, p} + {{PW{1'b0}}, 1'b1};

  // a is placed above FRAC_W zero bits and shifted down by p+1. The result
  // is below 1.0, so everything above the low QW bits is zero and the
  // cast drops nothing but those zero bits.
  assign m = QW'({a, {FRAC_W{1'b0}}} >> shamt);

  // Exactly one bit set <=> a & (a-1) == 0 with a non-zero.
  assign is_pow2 = (a != '0) &&
                   ((a & (a - {{(IN_W-1){1'b0}}, 1'b1})) == '0);

endmodule

// File: rtl/nr_reciprocal.sv
// nr_reciprocal
//   Newton-Raphson reciprocal: o_quotient ~= 2^FRAC_W / d in S1.FRAC_W.
//   The divisor is normalised to m in [0.5,1), 1/m is refined by ITER
//   Newton-Raphson passes from the seed 3-2m, then the result is shifted
//   back down by p+1 and negated for negative divisors. Powers of two skip
//   the iteration. A zero divisor saturates to max positive and sets o_div0.
//   Ports:
//     i_clk       in  1       clock, rising edge
//     i_rst_n     in  1       asynchronous active-low reset
//     i_valid     in  1       divisor present
//     o_ready     out 1       idle, divisor accepted on i_valid
//     i_divisor   in  IN_W    divisor (two's complement when SIGNED=1)
//     o_valid     out 1       quotient valid, held until i_ready
//     i_ready     in  1       downstream takes the quotient
//     o_quotient  out QW      S1.FRAC_W reciprocal
//     o_div0      out 1       divisor was zero (qualified by o_valid)
module nr_reciprocal #(
  parameter int IN_W   = 8,
  parameter int FRAC_W = 30,
  parameter int ITER   = 4,
  parameter int SIGNED = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [IN_W-1:0]   i_divisor,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [FRAC_W+1:0] o_quotient,
  output logic              o_div0
);
  import nr_recip_pkg::*;

  localparam int QW  = calc_qw(FRAC_W);
  localparam int PQW = 2 * QW;
  localparam int PW  = $clog2(IN_W);
  localparam int CW  = $clog2(ITER + 1);

  localparam logic [QW-1:0] TWO_C   = QW'(to_fx(TWO_FX, FRAC_W));
  localparam logic [QW-1:0] THREE_C = QW'(to_fx(THREE_FX, FRAC_W));
  localparam logic [QW-1:0] MAX_POS = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] LSB_C   = QW'(1);

  state_t          state;
  logic [IN_W-1:0] div_r;
  logic            sign_r;
  logic [PW-1:0]   p_r;
  logic [QW-1:0]   m_r;
  logic [QW-1:0]   x_r;
  logic [QW-1:0]   t_r;
  logic [CW-1:0]   cnt_r;

  logic            sign_d;
  logic [IN_W-1:0] abs_d;
  logic [PW-1:0]   p_n;
  logic [QW-1:0]   m_n;
  logic            pow2_n;

  logic [QW-1:0]   mul_a;
  logic [PQW-1:0]  prod;
  logic [QW-1:0]   prod_fx;
  logic [PW:0]     scale_sh;
  logic [QW-1:0]   scaled;

  assign o_ready = (state == IDLE);

  // Magnitude of the latched divisor. -(-2^(IN_W-1)) wraps to 2^(IN_W-1),
  // which is the correct unsigned magnitude, so IN_W bits are enough.
  always_comb begin
    sign_d = (SIGNED != 0) && div_r[IN_W-1];
    abs_d  = div_r;
    if (sign_d) begin
      abs_d = (~div_r) + {{(IN_W-1){1'b0}}, 1'b1};
    end
  end

  lead_one_norm #(
    .IN_W   (IN_W),
    .FRAC_W (FRAC_W)
  ) u_norm (
    .a       (abs_d),
    .p       (p_n),
    .m       (m_n),
    .is_pow2 (pow2_n)
  );

  // Single shared multiplier: m*x in ITER_A, t*x in ITER_B. Operands are
  // widened first so the full product is kept before the fixed-point
  // rescale, which truncates.
  assign mul_a   = (state == ITER_B) ? t_r : m_r;
  assign prod    = PQW'(mul_a) * PQW'(x_r);
  assign prod_fx = QW'(prod >> FRAC_W);

  // Undo the normalisation: 1/d = (1/m) / 2^(p+1).
  assign scale_sh = {1'b0, p_r} + {{PW{1'b0}}, 1'b1};
  assign scaled   = x_r >> scale_sh;

  // Control and datapath registers. Outputs are registered and only
  // change when a result is produced (NORM for divide-by-zero, SCALE
  // otherwise); o_valid drops on the edge that hands the result off.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      div_r      <= '0;
      sign_r     <= 1'b0;
      p_r        <= '0;
      m_r        <= '0;
      x_r        <= '0;
      t_r        <= '0;
      cnt_r      <= '0;
      o_valid    <= 1'b0;
      o_quotient <= '0;
      o_div0     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            div_r <= i_divisor;
            state <= NORM;
          end
        end

        NORM: begin
          sign_r <= sign_d;
          p_r    <= p_n;
          m_r    <= m_n;
          cnt_r  <= '0;
          if (abs_d == '0) begin
            o_quotient <= MAX_POS;
            o_div0     <= 1'b1;
            o_valid    <= 1'b1;
            state      <= DONE;
          end else if (pow2_n) begin
            x_r   <= TWO_C;
            state <= SCALE;
          end else begin
            // Seed 3 - 2m: m < 1 so the top bit of m is zero and the
            // doubling is an exact left shift.
            x_r   <= THREE_C - {m_n[QW-2:0], 1'b0};
            state <= ITER_A;
          end
        end

        ITER_A: begin
          t_r   <= TWO_C - prod_fx;
          state <= ITER_B;
        end

        ITER_B: begin
          x_r   <= prod_fx;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(ITER - 1)) begin
            state <= SCALE;
          end else begin
            state <= ITER_A;
          end
        end

        SCALE: begin
          o_quotient <= sign_r ? ((~scaled) + LSB_C) : scaled;
          o_div0     <= 1'b0;
          o_valid    <= 1'b1;
          state      <= DONE;
        end

        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
